// File: rtl/q_table_update_engine.sv
// q_table_update_engine
// Q-table register storage with a combinational row read port and a
// four-state read-modify-write engine applying the temporal-difference
// update Q(s,a) += alpha * (target - Q(s,a)) one request at a time.
module q_table_update_engine #(
    parameter int WIDTH   = 16,
    parameter int FRAC    = WIDTH / 2,
    parameter int ACTIONS = 4,
    parameter int STATES  = 16,
    parameter int SW      = $clog2(STATES),
    parameter int AW      = $clog2(ACTIONS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [SW-1:0]              upd_state,
    input  logic [AW-1:0]              upd_action,
    input  logic                       upd_done,
    input  logic [WIDTH-1:0]           reward,
    input  logic [WIDTH-1:0]           max_q_next,
    input  logic [WIDTH-1:0]           alpha,
    input  logic [WIDTH-1:0]           gamma,
    input  logic [SW-1:0]              rd_state,
    output logic [ACTIONS*WIDTH-1:0]   rd_q,
    output logic                       wb_valid,
    output logic                       wb_err,
    output logic [SW-1:0]              wb_state,
    output logic [AW-1:0]              wb_action,
    output logic [WIDTH-1:0]           wb_q
);

    localparam int ENTRIES = STATES * ACTIONS;

    typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

    state_t state_reg, state_next;

    // Captured request
    logic [SW-1:0]    req_state_reg;
    logic [AW-1:0]    req_action_reg;
    logic             req_done_reg;
    logic [WIDTH-1:0] req_reward_reg;
    logic [WIDTH-1:0] req_max_q_reg;
    logic [WIDTH-1:0] req_alpha_reg;
    logic [WIDTH-1:0] req_gamma_reg;

    // Pipeline registers between the FSM steps
    logic [WIDTH-1:0] q_old_reg;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] q_new_reg;

    // Write-back outputs
    logic             wb_valid_reg;
    logic             wb_err_reg;
    logic [SW-1:0]    wb_state_reg;
    logic [AW-1:0]    wb_action_reg;
    logic [WIDTH-1:0] wb_q_reg;

    // Flattened table: entry (s,a) lives at index s*ACTIONS+a
    logic [ENTRIES*WIDTH-1:0] tbl_flat;

    logic accept;
    logic req_in_range;
    int   req_index;
    logic wr_en;
    logic rd_in_range;

    // Datapath intermediates
    logic [2*WIDTH-1:0]        gm_prod;
    logic [2*WIDTH-1:0]        disc;
    logic [WIDTH-1:0]          disc_sat;
    logic [WIDTH:0]            tgt_sum;
    logic [WIDTH-1:0]          target_next;
    logic [WIDTH-1:0]          q_lookup;
    logic signed [WIDTH:0]     delta;
    logic signed [2*WIDTH+1:0] step_prod;
    logic signed [2*WIDTH+1:0] step;
    logic signed [2*WIDTH+1:0] q_sum;
    logic [WIDTH-1:0]          q_new_next;

    assign upd_ready    = (state_reg == IDLE) && !clr;
    assign accept       = upd_valid && upd_ready;
    assign req_in_range = (int'(req_state_reg) < STATES) && (int'(req_action_reg) < ACTIONS);
    assign req_index    = int'(req_state_reg) * ACTIONS + int'(req_action_reg);
    assign wr_en        = (state_reg == WRITE) && !clr && req_in_range;
    assign rd_in_range  = int'(rd_state) < STATES;

    assign wb_valid  = wb_valid_reg;
    assign wb_err    = wb_err_reg;
    assign wb_state  = wb_state_reg;
    assign wb_action = wb_action_reg;
    assign wb_q      = wb_q_reg;

    genvar gi;

    // One register per table entry; clr and reset wipe the whole table
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            logic             wr_hit;
            assign wr_hit = wr_en && (req_index == gi);
            // Entry storage with clear and single-port write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg <= '0;
                else if (clr)
                    entry_reg <= '0;
                else if (wr_hit)
                    entry_reg <= q_new_reg;
            end
            assign tbl_flat[gi*WIDTH +: WIDTH] = entry_reg;
        end
    endgenerate

    // Combinational row read; an out-of-range row reads as zeros
    generate
        for (gi = 0; gi < ACTIONS; gi++) begin : g_rd
            assign rd_q[gi*WIDTH +: WIDTH] = rd_in_range
                ? tbl_flat[(int'(rd_state) * ACTIONS + gi) * WIDTH +: WIDTH]
                : '0;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // FSM next state: one pass IDLE->READ->CALC->WRITE per request, clr aborts
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = CALC;
            CALC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr)
            state_next = IDLE;
    end

    // Target, old value lookup and TD step arithmetic
    always_comb begin
        // Discounted max-next-Q; saturating before the add keeps the
        // reward sum exact in WIDTH+1 bits even for large gamma products.
        gm_prod  = {{WIDTH{1'b0}}, req_gamma_reg} * {{WIDTH{1'b0}}, req_max_q_reg};
        disc     = gm_prod >> FRAC;
        disc_sat = (|disc[2*WIDTH-1:WIDTH]) ? '1 : disc[WIDTH-1:0];
        tgt_sum  = {1'b0, req_reward_reg} + {1'b0, disc_sat};
        if (req_done_reg)
            target_next = req_reward_reg;
        else if (tgt_sum[WIDTH])
            target_next = '1;
        else
            target_next = tgt_sum[WIDTH-1:0];

        q_lookup = '0;
        if (req_in_range)
            q_lookup = tbl_flat[req_index * WIDTH +: WIDTH];

        // Signed step: alpha is zero-extended, delta sign-extended; >>> floors
        delta     = $signed({1'b0, target_reg}) - $signed({1'b0, q_old_reg});
        step_prod = $signed({{(WIDTH+2){1'b0}}, req_alpha_reg})
                  * $signed({{(WIDTH+1){delta[WIDTH]}}, delta});
        step      = step_prod >>> FRAC;
        q_sum     = step + $signed({{(WIDTH+2){1'b0}}, q_old_reg});
        if (q_sum[2*WIDTH+1])
            q_new_next = '0;
        else if (|q_sum[2*WIDTH:WIDTH])
            q_new_next = '1;
        else
            q_new_next = q_sum[WIDTH-1:0];
    end

    // Request capture at accept and per-step pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_state_reg  <= '0;
            req_action_reg <= '0;
            req_done_reg   <= 1'b0;
            req_reward_reg <= '0;
            req_max_q_reg  <= '0;
            req_alpha_reg  <= '0;
            req_gamma_reg  <= '0;
            q_old_reg      <= '0;
            target_reg     <= '0;
            q_new_reg      <= '0;
        end else begin
            if (accept) begin
                req_state_reg  <= upd_state;
                req_action_reg <= upd_action;
                req_done_reg   <= upd_done;
                req_reward_reg <= reward;
                req_max_q_reg  <= max_q_next;
                req_alpha_reg  <= alpha;
                req_gamma_reg  <= gamma;
            end
            if (state_reg == READ && !clr) begin
                q_old_reg  <= q_lookup;
                target_reg <= target_next;
            end
            if (state_reg == CALC && !clr)
                q_new_reg <= q_new_next;
        end
    end

    // Write-back report: one-cycle pulse after WRITE, fields hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg  <= 1'b0;
            wb_err_reg    <= 1'b0;
            wb_state_reg  <= '0;
            wb_action_reg <= '0;
            wb_q_reg      <= '0;
        end else if (clr) begin
            wb_valid_reg <= 1'b0;
        end else if (state_reg == WRITE) begin
            wb_valid_reg  <= 1'b1;
            wb_err_reg    <= !req_in_range;
            wb_state_reg  <= req_state_reg;
            wb_action_reg <= req_action_reg;
            wb_q_reg      <= req_in_range ? q_new_reg : '0;
        end else begin
            wb_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_q_table_update_engine.sv
// Scoreboard bench for q_table_update_engine: stimulus pushes hand-computed
// write-back expectations, a negedge monitor pops and compares them.
module tb_q_table_update_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        upd_valid;
    logic        upd_ready;
    logic [4:0]  upd_state;
    logic [1:0]  upd_action;
    logic        upd_done;
    logic [15:0] reward;
    logic [15:0] max_q_next;
    logic [15:0] alpha;
    logic [15:0] gamma;
    logic [4:0]  rd_state;
    logic [63:0] rd_q;
    logic        wb_valid;
    logic        wb_err;
    logic [4:0]  wb_state;
    logic [1:0]  wb_action;
    logic [15:0] wb_q;

    // State index widened to 5 bits so out-of-range states can be driven
    q_table_update_engine #(
        .WIDTH(16), .FRAC(8), .ACTIONS(4), .STATES(16), .SW(5), .AW(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_state(upd_state), .upd_action(upd_action), .upd_done(upd_done),
        .reward(reward), .max_q_next(max_q_next), .alpha(alpha), .gamma(gamma),
        .rd_state(rd_state), .rd_q(rd_q),
        .wb_valid(wb_valid), .wb_err(wb_err), .wb_state(wb_state),
        .wb_action(wb_action), .wb_q(wb_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [4:0]  st;
        logic [1:0]  ac;
        logic [15:0] q;
    } exp_t;

    exp_t        sb_q[$];
    int          acc_q[$];
    int          acc_hist[$];
    logic [15:0] exp_tab [16][4];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          wb_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log accepts, compare every write-back against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (rst_n) begin
            if (clr) begin
                sb_q.delete();
                acc_q.delete();
            end else if (upd_valid && upd_ready) begin
                acc_q.push_back(cyc + 1);
                acc_hist.push_back(cyc + 1);
            end
            if (wb_valid) begin
                wb_cnt++;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got wb_valid=1 state=%0d, expected no write-back", wb_state);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("wb_err s%0d", e.st), wb_err, e.err);
                    check($sformatf("wb_state s%0d", e.st), wb_state, e.st);
                    check($sformatf("wb_action s%0d", e.st), wb_action, e.ac);
                    check($sformatf("wb_q s%0d a%0d", e.st, e.ac), wb_q, e.q);
                end
                if (acc_q.size() != 0) begin
                    a = acc_q.pop_front();
                    check("wb_latency", cyc - a, 3);
                end
            end
        end
    end

    // Wait (bounded) until every expected write-back has been seen
    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [4:0] s, input logic [1:0] a, input logic done,
                          input logic [15:0] rw, input logic [15:0] mq,
                          input logic [15:0] al, input logic [15:0] gm,
                          input logic [15:0] expq, input bit wait_wb);
        int   n = 0;
        exp_t e;
        upd_state = s; upd_action = a; upd_done = done;
        reward = rw; max_q_next = mq; alpha = al; gamma = gm;
        upd_valid = 1'b1;
        while (!upd_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!upd_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got upd_ready=0, expected 1");
            upd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        e.err = (s >= 5'd16);
        e.st  = s;
        e.ac  = a;
        e.q   = e.err ? 16'h0000 : expq;
        sb_q.push_back(e);
        if (!e.err) exp_tab[s[3:0]][a] = expq;
        if (wait_wb) drain();
    endtask

    task automatic check_table();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            rd_state = 5'(s);
            #1;
            check($sformatf("table_row%0d", s), rd_q,
                  {exp_tab[s][3], exp_tab[s][2], exp_tab[s][1], exp_tab[s][0]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int wb_before;
        rst_n = 1'b0; clr = 1'b0; upd_valid = 1'b0;
        upd_state = '0; upd_action = '0; upd_done = 1'b0;
        reward = '0; max_q_next = '0; alpha = '0; gamma = '0; rd_state = '0;
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 4; a++)
                exp_tab[s][a] = 16'h0000;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_upd_ready", upd_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_err", wb_err, 0);
        check("rst_wb_state", wb_state, 0);
        check("rst_wb_action", wb_action, 0);
        check("rst_wb_q", wb_q, 0);
        check_table();
        @(posedge clk);
        #1;

        // Basic update: old value visible through E3, new value after
        rd_state = 5'd3;
        do_req(5'd3, 2'd1, 1'b0, 16'h0400, 16'h0200, 16'h0080, 16'h0080, 16'h0280, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("row3_old_cycle%0d", k), rd_q[31:16], 16'h0000);
        end
        @(negedge clk);
        check("row3_new", rd_q[31:16], 16'h0280);
        drain();

        // Decay with negative step, then floor toward -inf
        do_req(5'd3, 2'd1, 1'b1, 16'h0000, 16'h0500, 16'h0080, 16'h0080, 16'h0140, 1'b1);
        do_req(5'd5, 2'd2, 1'b1, 16'h0001, 16'h0000, 16'h0100, 16'h0000, 16'h0001, 1'b1);
        do_req(5'd5, 2'd2, 1'b1, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 1'b1);

        // Target saturation, lower and upper clamp
        do_req(5'd7, 2'd3, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100, 16'hFFFF, 1'b1);
        do_req(5'd2, 2'd0, 1'b1, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        do_req(5'd2, 2'd0, 1'b1, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 1'b1);
        do_req(5'd8, 2'd0, 1'b1, 16'h8000, 16'h0000, 16'h0100, 16'h0000, 16'h8000, 1'b1);
        do_req(5'd8, 2'd0, 1'b1, 16'hFFFF, 16'h0000, 16'h0200, 16'h0000, 16'hFFFF, 1'b1);
        check_table();
        @(posedge clk);
        #1;

        // Handshake: valid held high, inputs churn while busy
        begin
            exp_t e;
            upd_state = 5'd10; upd_action = 2'd1; upd_done = 1'b1;
            reward = 16'h0300; max_q_next = 16'h0000; alpha = 16'h0100; gamma = 16'h0000;
            upd_valid = 1'b1;
            @(posedge clk);
            #1;
            e.err = 1'b0; e.st = 5'd10; e.ac = 2'd1; e.q = 16'h0300;
            sb_q.push_back(e);
            exp_tab[10][1] = 16'h0300;
            for (int k = 0; k < 3; k++) begin
                upd_state = 5'd11; upd_action = 2'd2; upd_done = 1'b0;
                reward = 16'h1234 + 16'(k); max_q_next = 16'hFFFF;
                alpha = 16'h0100; gamma = 16'h0100;
                @(negedge clk);
                check($sformatf("ready_busy%0d", k), upd_ready, 0);
                @(posedge clk);
                #1;
            end
            upd_state = 5'd20; upd_action = 2'd0; upd_done = 1'b1;
            reward = 16'h0777; alpha = 16'h0100;
            @(negedge clk);
            check("ready_after_e3", upd_ready, 1);
            @(posedge clk);
            #1;
            upd_valid = 1'b0;
            e.err = 1'b1; e.st = 5'd20; e.ac = 2'd0; e.q = 16'h0000;
            sb_q.push_back(e);
            drain();
            if (acc_hist.size() >= 2)
                check("accept_gap", acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2], 4);
            else
                check("accept_count", acc_hist.size(), 2);
        end
        check_table();
        @(negedge clk);
        rd_state = 5'd20;
        #1;
        check("row20_zero", rd_q, 64'h0);
        @(posedge clk);
        #1;

        // clr in the cycle after E1 aborts the request and wipes the table
        wb_before = wb_cnt;
        upd_state = 5'd3; upd_action = 2'd1; upd_done = 1'b1;
        reward = 16'h0999; max_q_next = 16'h0000; alpha = 16'h0100; gamma = 16'h0000;
        upd_valid = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(negedge clk);
        check("ready_during_clr", upd_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("ready_after_clr", upd_ready, 1);
        repeat (6) @(negedge clk);
        check("no_wb_after_clr", wb_cnt, wb_before);
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 4; a++)
                exp_tab[s][a] = 16'h0000;
        check_table();
        @(posedge clk);
        #1;

        // Engine still functional after the abort
        do_req(5'd4, 2'd2, 1'b1, 16'h0050, 16'h0000, 16'h0100, 16'h0000, 16'h0050, 1'b1);
        check_table();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
